// File: rtl/tlc_pkg.sv
// tlc_pkg: shared widths, tick divider and light-interval constants for the traffic light controller
package tlc_pkg;
  localparam int TLC_TIMER_W  = 13;
  localparam int TLC_TICK_DIV = 50000;
  localparam int T_A_GREEN    = 4999;
  localparam int T_B_GREEN    = 3999;
  localparam int T_EXT        = 999;
  function automatic int presc_w(input int div);
    return div > 1 ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/tlc_timer_if.sv
// tlc_timer_if: controller <-> timer signals; pause exists only with TLC_TIMER_PAUSE_EN
interface tlc_timer_if import tlc_pkg::*; #(parameter int N = TLC_TIMER_W) ();
  logic         timer_reset;
  logic [N-1:0] final_value;
  logic         timer_done;
  logic [N-1:0] elapsed;
`ifdef TLC_TIMER_PAUSE_EN
  logic         pause;
  modport master (output timer_reset, final_value, pause, input timer_done, elapsed);
  modport slave  (input timer_reset, final_value, pause, output timer_done, elapsed);
`else
  modport master (output timer_reset, final_value, input timer_done, elapsed);
  modport slave  (input timer_reset, final_value, output timer_done, elapsed);
`endif
endinterface

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: prescaler producing a one-cycle tick every TICK_DIV enabled clocks
module tlc_tick_gen import tlc_pkg::*; #(
  parameter int TICK_DIV = TLC_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = presc_w(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] presc;
  assign tick = enable & (presc == LAST);
  always_ff @(posedge clk or posedge reset)
    if (reset) presc <= '0;
    else if (clear) presc <= '0;
    else if (enable) presc <= tick ? '0 : presc + 1'b1;
endmodule

// File: rtl/tlc_timer.sv
// tlc_timer: auto-reloading interval timer (final_value+1 ticks); optional pause via TLC_TIMER_PAUSE_EN
module tlc_timer import tlc_pkg::*; #(
  parameter int N        = TLC_TIMER_W,
  parameter int TICK_DIV = TLC_TICK_DIV
) (
  input logic        clk,
  input logic        reset,
  tlc_timer_if.slave bus
);
  logic         restart, tick, terminal, run, done_q;
  logic [N-1:0] fv_q, elapsed_q;
`ifdef TLC_TIMER_PAUSE_EN
  assign run = ~bus.pause;
`else
  assign run = 1'b1;
`endif
  // a changed final_value restarts the interval so elapsed never lingers above it
  assign restart  = bus.timer_reset | (bus.final_value != fv_q);
  assign terminal = elapsed_q >= bus.final_value;
  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .reset(reset), .clear(restart), .enable(run), .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fv_q      <= '0;
      elapsed_q <= '0;
      done_q    <= 1'b0;
    end else begin
      fv_q      <= bus.final_value;
      done_q    <= ~restart & tick & terminal;
      elapsed_q <= (restart || (tick && terminal)) ? '0 : tick ? elapsed_q + 1'b1 : elapsed_q;
    end
  assign bus.timer_done = done_q;
  assign bus.elapsed    = elapsed_q;
endmodule

// File: tb/tb_tlc_timer.sv
// tb_tlc_timer: scoreboard bench, expected done cycles queued at stimulus, popped when timer_done fires
module tb_tlc_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_q[$];
  tlc_timer_if #(.N(13)) bus ();
  tlc_timer #(.N(13), .TICK_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.timer_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_spurious at cyc=%0d, no pulse expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL done_time got cyc=%0d want cyc=%0d", cyc, e);
        end
      end
    end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
  endtask
  task automatic test_reset();
    step();
    checks++;
    if (bus.elapsed !== 13'd0 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state elapsed=%0d done=%b want 0/0", bus.elapsed, bus.timer_done);
    end
  endtask
  task automatic test_period();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) exp_q.push_back(cyc + 1 + 12 * i);
    drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL period_timeout pending=%0d want 0", exp_q.size());
    end
  endtask
`ifdef TLC_TIMER_PAUSE_EN
  task automatic test_pause();
    int d;
    d = cyc;
    repeat (3) step();
    bus.pause = 1'b1;
    exp_q.push_back(d + 22);
    repeat (10) step();
    bus.pause = 1'b0;
    drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pause_timeout pending=%0d want 0", exp_q.size());
    end
  endtask
`endif
  task automatic test_fv_zero();
    int r;
    bus.final_value = 13'd0;
    r = cyc + 1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(r + 4 * i);
    repeat (16) begin
      step();
      checks++;
      if (bus.elapsed !== 13'd0) begin
        errors++;
        $display("FAIL fv0_elapsed got=%0d want 0", bus.elapsed);
      end
    end
    drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL fv0_timeout pending=%0d want 0", exp_q.size());
    end
  endtask
  task automatic test_timer_reset();
    bus.final_value = 13'd9;
    for (int i = 0; i < 100 && bus.elapsed !== 13'd5; i++) step();
    checks++;
    if (bus.elapsed !== 13'd5) begin
      errors++;
      $display("FAIL tr_reach5 elapsed=%0d want 5", bus.elapsed);
    end
    bus.timer_reset = 1'b1;
    exp_q.push_back(cyc + 41);
    step();
    bus.timer_reset = 1'b0;
    checks++;
    if (bus.elapsed !== 13'd0 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL tr_clear elapsed=%0d done=%b want 0/0", bus.elapsed, bus.timer_done);
    end
    drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL tr_timeout pending=%0d want 0", exp_q.size());
    end
  endtask
  task automatic test_fv_change();
    for (int i = 0; i < 100 && bus.elapsed !== 13'd7; i++) step();
    checks++;
    if (bus.elapsed !== 13'd7) begin
      errors++;
      $display("FAIL fvc_reach7 elapsed=%0d want 7", bus.elapsed);
    end
    bus.final_value = 13'd3;
    exp_q.push_back(cyc + 17);
    step();
    checks++;
    if (bus.elapsed !== 13'd0) begin
      errors++;
      $display("FAIL fvc_clear elapsed=%0d want 0", bus.elapsed);
    end
    drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL fvc_timeout pending=%0d want 0", exp_q.size());
    end
  endtask
  task automatic test_coincident();
    repeat (15) step();
    bus.timer_reset = 1'b1;
    step();
    bus.timer_reset = 1'b0;
    exp_q.push_back(cyc + 16);
    checks++;
    if (bus.elapsed !== 13'd0 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL coinc_state elapsed=%0d done=%b want 0/0", bus.elapsed, bus.timer_done);
    end
    drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL coinc_timeout pending=%0d want 0", exp_q.size());
    end
  endtask
  task automatic test_reset_abort();
    repeat (6) step();
    checks++;
    if (bus.elapsed === 13'd0) begin
      errors++;
      $display("FAIL abort_running elapsed=%0d want nonzero", bus.elapsed);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.elapsed !== 13'd0 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async elapsed=%0d done=%b want 0/0", bus.elapsed, bus.timer_done);
    end
    repeat (3) step();
    reset = 1'b0;
    exp_q.push_back(cyc + 17);
    drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_timeout pending=%0d want 0", exp_q.size());
    end
  endtask
  initial begin
    bus.timer_reset = 1'b0;
    bus.final_value = 13'd2;
`ifdef TLC_TIMER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    test_reset();
    test_period();
`ifdef TLC_TIMER_PAUSE_EN
    test_pause();
`endif
    test_fv_zero();
    test_timer_reset();
    test_fv_change();
    test_coincident();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
